// File: rtl/cpu_ad48_bpred.sv
// Direct-mapped branch target buffer with saturating direction counters.
// Table is invalidated by a sequential INIT sweep after reset or flush; lookups are registered.
module cpu_ad48_bpred #(
  parameter int ADDR_W  = 48,
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 12,
  parameter int CTR_W   = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              lk_valid,
  input  logic [ADDR_W-1:0] lk_pc,
  input  logic              up_valid,
  input  logic [ADDR_W-1:0] up_pc,
  input  logic              up_taken,
  input  logic [ADDR_W-1:0] up_target,
  output logic              ready,
  output logic              pred_valid,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  output logic              dbg_state
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(1) << (CTR_W - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ENTRIES - 1);

  typedef enum logic {ST_INIT = 1'b0, ST_READY = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] clr_idx, clr_idx_nxt;
  logic             clr_en;

  logic              tbl_valid  [ENTRIES];
  logic [TAG_W-1:0]  tbl_tag    [ENTRIES];
  logic [CTR_W-1:0]  tbl_ctr    [ENTRIES];
  logic [ADDR_W-1:0] tbl_target [ENTRIES];

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             lk_hit, up_hit, up_en;

  assign lk_idx = lk_pc[IDX_W-1:0];
  assign lk_tag = lk_pc[IDX_W+TAG_W-1:IDX_W];
  assign up_idx = up_pc[IDX_W-1:0];
  assign up_tag = up_pc[IDX_W+TAG_W-1:IDX_W];

  generate
    if (ADDR_W > IDX_W + TAG_W) begin : g_unused_pc
      logic unused_pc_bits;
      assign unused_pc_bits = ^{lk_pc[ADDR_W-1:IDX_W+TAG_W], up_pc[ADDR_W-1:IDX_W+TAG_W]};
    end
  endgenerate

  assign ready     = (state == ST_READY);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= ST_INIT;
      clr_idx <= '0;
    end else begin
      state   <= state_nxt;
      clr_idx <= clr_idx_nxt;
    end
  end

  // A flush during INIT restarts the sweep so every entry is cleared after the last flush.
  always_comb begin
    state_nxt   = state;
    clr_idx_nxt = clr_idx;
    clr_en      = 1'b0;
    case (state)
      ST_INIT: begin
        clr_en = 1'b1;
        if (flush) begin
          clr_idx_nxt = '0;
        end else if (clr_idx == IDX_LAST) begin
          state_nxt   = ST_READY;
          clr_idx_nxt = '0;
        end else begin
          clr_idx_nxt = clr_idx + 1'b1;
        end
      end
      ST_READY: begin
        if (flush) begin
          state_nxt   = ST_INIT;
          clr_idx_nxt = '0;
        end
      end
      default: begin
        state_nxt   = ST_INIT;
        clr_idx_nxt = '0;
      end
    endcase
  end

  assign lk_hit = ready && tbl_valid[lk_idx] && (tbl_tag[lk_idx] == lk_tag);
  assign up_hit = tbl_valid[up_idx] && (tbl_tag[up_idx] == up_tag);
  assign up_en  = ready && up_valid && !flush;

  // Registered read of the current table contents, so a same-cycle update is not visible.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pred_valid  <= 1'b0;
      pred_hit    <= 1'b0;
      pred_taken  <= 1'b0;
      pred_target <= '0;
    end else begin
      pred_valid  <= lk_valid;
      pred_hit    <= lk_valid && lk_hit;
      pred_taken  <= lk_valid && lk_hit && tbl_ctr[lk_idx][CTR_W-1];
      pred_target <= (lk_valid && lk_hit) ? tbl_target[lk_idx] : '0;
    end
  end

  // Table storage has no reset; INIT and updates are mutually exclusive by state.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      tbl_valid[clr_idx] <= 1'b0;
    end
    if (up_en) begin
      if (up_hit) begin
        if (up_taken) begin
          if (tbl_ctr[up_idx] != CTR_MAX) tbl_ctr[up_idx] <= tbl_ctr[up_idx] + 1'b1;
          tbl_target[up_idx] <= up_target;
        end else if (tbl_ctr[up_idx] != '0) begin
          tbl_ctr[up_idx] <= tbl_ctr[up_idx] - 1'b1;
        end
      end else if (up_taken) begin
        tbl_valid[up_idx]  <= 1'b1;
        tbl_tag[up_idx]    <= up_tag;
        tbl_ctr[up_idx]    <= CTR_INIT;
        tbl_target[up_idx] <= up_target;
      end
    end
  end

endmodule

// File: tb/tb_cpu_ad48_bpred.sv
// Directed bench for cpu_ad48_bpred: init sweep timing, counter saturation, aliasing,
// same-cycle lookup/update ordering, flush and reset restart of INIT.
module tb_cpu_ad48_bpred;

  logic        clk;
  logic        resetn;
  logic        flush;
  logic        lk_valid;
  logic [47:0] lk_pc;
  logic        up_valid;
  logic [47:0] up_pc;
  logic        up_taken;
  logic [47:0] up_target;
  logic        ready;
  logic        pred_valid;
  logic        pred_hit;
  logic        pred_taken;
  logic [47:0] pred_target;
  logic        dbg_state;

  int tests = 0;
  int fails = 0;

  cpu_ad48_bpred dut (
    .clk        (clk),
    .resetn     (resetn),
    .flush      (flush),
    .lk_valid   (lk_valid),
    .lk_pc      (lk_pc),
    .up_valid   (up_valid),
    .up_pc      (up_pc),
    .up_taken   (up_taken),
    .up_target  (up_target),
    .ready      (ready),
    .pred_valid (pred_valid),
    .pred_hit   (pred_hit),
    .pred_taken (pred_taken),
    .pred_target(pred_target),
    .dbg_state  (dbg_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input logic [47:0] pc);
    lk_valid = 1'b1;
    lk_pc    = pc;
    tick();
    lk_valid = 1'b0;
  endtask

  task automatic update(input logic [47:0] pc, input logic taken, input logic [47:0] tgt);
    up_valid  = 1'b1;
    up_pc     = pc;
    up_taken  = taken;
    up_target = tgt;
    tick();
    up_valid  = 1'b0;
  endtask

  task automatic check_pred(input string tag, input logic hit, input logic tkn, input logic [47:0] tgt);
    check({tag, ".valid"},  {47'd0, pred_valid}, 48'd1);
    check({tag, ".hit"},    {47'd0, pred_hit},   {47'd0, hit});
    check({tag, ".taken"},  {47'd0, pred_taken}, {47'd0, tkn});
    check({tag, ".target"}, pred_target, tgt);
  endtask

  initial begin
    resetn = 1'b0; flush = 1'b0; lk_valid = 1'b0; lk_pc = '0;
    up_valid = 1'b0; up_pc = '0; up_taken = 1'b0; up_target = '0;

    // Reset state, with a lookup held to show pred_valid is forced low.
    lk_valid = 1'b1; lk_pc = 48'h28;
    repeat (3) tick();
    lk_valid = 1'b0;
    check("rst.ready",      {47'd0, ready},      48'd0);
    check("rst.pred_valid", {47'd0, pred_valid}, 48'd0);
    check("rst.pred_hit",   {47'd0, pred_hit},   48'd0);
    check("rst.pred_taken", {47'd0, pred_taken}, 48'd0);
    check("rst.pred_target", pred_target,        48'd0);
    check("rst.state",      {47'd0, dbg_state},  48'd0);

    // INIT lasts 16 cycles; lookup during INIT is a miss.
    resetn = 1'b1;
    check("init0.ready", {47'd0, ready}, 48'd0);
    for (int i = 1; i <= 16; i++) begin
      if (i == 4) begin lk_valid = 1'b1; lk_pc = 48'h28; end
      tick();
      lk_valid = 1'b0;
      check($sformatf("init.ready[%0d]", i), {47'd0, ready}, (i == 16) ? 48'd1 : 48'd0);
      if (i == 4) check_pred("init.lk", 1'b0, 1'b0, 48'h0);
      if (i == 5) check("init.pv_once", {47'd0, pred_valid}, 48'd0);
    end
    check("ready.state", {47'd0, dbg_state}, 48'd1);

    // Allocation at 0x0D, ctr=2.
    update(48'h0D, 1'b1, 48'h28);
    lookup(48'h0D);
    check_pred("alloc", 1'b1, 1'b1, 48'h28);
    tick();
    check("pv_idle", {47'd0, pred_valid}, 48'd0);
    update(48'h0D, 1'b0, 48'h0);
    update(48'h0D, 1'b0, 48'h0);
    lookup(48'h0D);
    check_pred("nt2", 1'b1, 1'b0, 48'h28);
    update(48'h0D, 1'b0, 48'h0);
    lookup(48'h0D);
    check_pred("nt_sat0", 1'b1, 1'b0, 48'h28);

    // 0 -> 3 via three taken, fourth taken must stay at 3.
    update(48'h0D, 1'b1, 48'h28);
    update(48'h0D, 1'b1, 48'h28);
    update(48'h0D, 1'b1, 48'h28);
    update(48'h0D, 1'b1, 48'h28);
    lookup(48'h0D);
    check_pred("t_sat3", 1'b1, 1'b1, 48'h28);
    update(48'h0D, 1'b0, 48'h0);
    lookup(48'h0D);
    check_pred("ctr2", 1'b1, 1'b1, 48'h28);
    update(48'h0D, 1'b0, 48'h0);
    lookup(48'h0D);
    check_pred("ctr1", 1'b1, 1'b0, 48'h28);

    // Alias 0x1D shares index 13 with 0x0D.
    lookup(48'h1D);
    check_pred("alias.miss", 1'b0, 1'b0, 48'h0);
    update(48'h1D, 1'b0, 48'h99);
    lookup(48'h0D);
    check_pred("alias.nt_keep", 1'b1, 1'b0, 48'h28);
    update(48'h1D, 1'b1, 48'h40);
    lookup(48'h1D);
    check_pred("alias.repl", 1'b1, 1'b1, 48'h40);
    lookup(48'h0D);
    check_pred("alias.evicted", 1'b0, 1'b0, 48'h0);
    update(48'h1D, 1'b1, 48'h50);
    lookup(48'h1D);
    check_pred("hit_t.target", 1'b1, 1'b1, 48'h50);

    // Same-cycle lookup and update see pre-update contents.
    lk_valid = 1'b1; lk_pc = 48'h05;
    up_valid = 1'b1; up_pc = 48'h05; up_taken = 1'b1; up_target = 48'h77;
    tick();
    lk_valid = 1'b0; up_valid = 1'b0;
    check_pred("same_cyc", 1'b0, 1'b0, 48'h0);
    lookup(48'h05);
    check_pred("same_cyc.next", 1'b1, 1'b1, 48'h77);
    lookup(48'h1000_0000_0005);
    check_pred("hi_bits_ignored", 1'b1, 1'b1, 48'h77);

    // Flush in READY, then reset at INIT cycle 8.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush.ready", {47'd0, ready}, 48'd0);
    repeat (7) tick();
    lookup(48'h1D);
    check_pred("flush.lk", 1'b0, 1'b0, 48'h0);
    resetn = 1'b0;
    #1;
    check("arst.pred_valid", {47'd0, pred_valid}, 48'd0);
    check("arst.ready",      {47'd0, ready},      48'd0);
    repeat (2) tick();
    resetn = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      if (i == 2) begin
        up_valid = 1'b1; up_pc = 48'h0D; up_taken = 1'b1; up_target = 48'h99;
      end
      if (i == 6) begin lk_valid = 1'b1; lk_pc = 48'h05; end
      tick();
      up_valid = 1'b0; lk_valid = 1'b0;
      check($sformatf("reinit.ready[%0d]", i), {47'd0, ready}, (i == 16) ? 48'd1 : 48'd0);
      if (i == 6) check_pred("reinit.lk", 1'b0, 1'b0, 48'h0);
    end
    lookup(48'h05);
    check_pred("cleared.05", 1'b0, 1'b0, 48'h0);
    lookup(48'h1D);
    check_pred("cleared.1d", 1'b0, 1'b0, 48'h0);
    lookup(48'h0D);
    check_pred("init_upd_ignored", 1'b0, 1'b0, 48'h0);

    // Flush during INIT restarts the sweep.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (5) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      check($sformatf("reflush.ready[%0d]", i), {47'd0, ready}, (i == 16) ? 48'd1 : 48'd0);
    end
    update(48'h28, 1'b1, 48'h11);
    lookup(48'h28);
    check_pred("post_flush.alloc", 1'b1, 1'b1, 48'h11);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
